ex_operand_stage: RTL

//  ID/EX pipeline register plus execute-stage operand forwarding; directly feeds the ALU (mux1, mux2, AluSel).

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/ex_operand_stage_fwd_select.sv | 30 +++
 rtl/ex_operand_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU select codes and the values
// that make up a pipeline bubble.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [SEL_W-1:0] ALU_SRL  = 4'd2;
  localparam logic [SEL_W-1:0] ALU_SLL  = 4'd3;
  localparam logic [SEL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [SEL_W-1:0] ALU_OR   = 4'd5;
  localparam logic [SEL_W-1:0] ALU_AND  = 4'd6;
  localparam logic [SEL_W-1:0] ALU_SLT  = 4'd7;
  localparam logic [SEL_W-1:0] ALU_SLTU = 4'd8;
  localparam logic [SEL_W-1:0] ALU_SRA  = 4'd9;

  // A bubble carries an add select and no side effects.
  localparam logic [SEL_W-1:0] NOP_ALU_SEL = ALU_ADD;
  localparam logic             NOP_VALID   = 1'b0;
  localparam logic             NOP_REG_WEN = 1'b0;
  localparam logic             NOP_IS_LOAD = 1'b0;

  // True when a later stage will write register rs with a usable value.
  // x0 is hard-wired to zero, so it never matches.
  function automatic logic wb_hit(input logic valid, input logic wen,
                                  input logic [RA_W-1:0] rd,
                                  input logic [RA_W-1:0] rs);
    return valid & wen & (rd != '0) & (rd == rs);
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_select.sv
// Three-way priority forwarding mux for one ALU source register.
// The younger EX/MEM result wins over MEM/WB; otherwise the value captured
// into the EX register is used.
module fwd_select
  import cpu_pkg::*;
(
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] reg_val,
  input  logic            m_valid,
  input  logic            m_reg_wen,
  input  logic [RA_W-1:0] m_rd,
  input  logic [XLEN-1:0] m_result,
  input  logic            w_valid,
  input  logic            w_reg_wen,
  input  logic [RA_W-1:0] w_rd,
  input  logic [XLEN-1:0] w_data,
  output logic [XLEN-1:0] value
);

  // Pick the freshest in-flight value for rs.
  always_comb begin
    value = reg_val;
    if (wb_hit(m_valid, m_reg_wen, m_rd, rs)) begin
      value = m_result;
    end else if (wb_hit(w_valid, w_reg_wen, w_rd, rs)) begin
      value = w_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with execute-stage operand forwarding, load-use
// bubble insertion, branch flush and downstream hold. Drives the ALU inputs.
module ex_operand_stage
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [XLEN-1:0]   d_pc,
  input  logic [XLEN-1:0]   d_rs1_data,
  input  logic [XLEN-1:0]   d_rs2_data,
  input  logic [XLEN-1:0]   d_imm,
  input  logic [RA_W-1:0]   d_rs1,
  input  logic [RA_W-1:0]   d_rs2,
  input  logic [RA_W-1:0]   d_rd,
  input  logic [SEL_W-1:0]  d_alu_sel,
  input  logic              d_asel,
  input  logic              d_bsel,
  input  logic              d_reg_wen,
  input  logic              d_is_load,
  input  logic              m_valid,
  input  logic              m_reg_wen,
  input  logic [RA_W-1:0]   m_rd,
  input  logic [XLEN-1:0]   m_result,
  input  logic              w_valid,
  input  logic              w_reg_wen,
  input  logic [RA_W-1:0]   w_rd,
  input  logic [XLEN-1:0]   w_data,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_d,
  output logic [XLEN-1:0]   mux1,
  output logic [XLEN-1:0]   mux2,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              e_valid,
  output logic [XLEN-1:0]   e_pc,
  output logic [XLEN-1:0]   e_store_data,
  output logic [RA_W-1:0]   e_rd,
  output logic              e_reg_wen,
  output logic              e_is_load
);

  logic [XLEN-1:0] e_imm;
  logic [XLEN-1:0] e_rs1_val;
  logic [XLEN-1:0] e_rs2_val;
  logic [RA_W-1:0] e_rs1;
  logic [RA_W-1:0] e_rs2;
  logic            e_asel;
  logic            e_bsel;
  logic            e_wen_q;
  logic            e_load_q;

  logic            load_use;
  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load in EX cannot feed a dependent instruction in decode; rs2 is
  // compared even when the immediate is selected, to keep the check simple.
  assign load_use = e_valid & e_load_q & (e_rd != '0) & d_valid &
                    ((d_rs1 == e_rd) | (d_rs2 == e_rd));
  assign stall_d  = load_use | hold;

  // Writeback happening this cycle has not reached the register file read.
  assign cap_rs1 = wb_hit(w_valid, w_reg_wen, w_rd, d_rs1) ? w_data : d_rs1_data;
  assign cap_rs2 = wb_hit(w_valid, w_reg_wen, w_rd, d_rs2) ? w_data : d_rs2_data;

  // EX register: reset, then flush, hold, load-use bubble, normal capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      e_valid   <= 1'b0;
      e_pc      <= '0;
      e_imm     <= '0;
      e_rs1_val <= '0;
      e_rs2_val <= '0;
      e_rs1     <= '0;
      e_rs2     <= '0;
      e_rd      <= '0;
      alu_sel   <= '0;
      e_asel    <= 1'b0;
      e_bsel    <= 1'b0;
      e_wen_q   <= 1'b0;
      e_load_q  <= 1'b0;
    end else if (flush || (!hold && load_use)) begin
      e_valid   <= NOP_VALID;
      alu_sel   <= NOP_ALU_SEL;
      e_wen_q   <= NOP_REG_WEN;
      e_load_q  <= NOP_IS_LOAD;
    end else if (!hold) begin
      e_valid   <= d_valid;
      e_pc      <= d_pc;
      e_imm     <= d_imm;
      e_rs1_val <= cap_rs1;
      e_rs2_val <= cap_rs2;
      e_rs1     <= d_rs1;
      e_rs2     <= d_rs2;
      e_rd      <= d_rd;
      alu_sel   <= d_alu_sel;
      e_asel    <= d_asel;
      e_bsel    <= d_bsel;
      e_wen_q   <= d_reg_wen;
      e_load_q  <= d_is_load;
    end
  end

  fwd_select u_fwd_rs1 (
    .rs(e_rs1), .reg_val(e_rs1_val),
    .m_valid(m_valid), .m_reg_wen(m_reg_wen), .m_rd(m_rd), .m_result(m_result),
    .w_valid(w_valid), .w_reg_wen(w_reg_wen), .w_rd(w_rd), .w_data(w_data),
    .value(fwd_rs1)
  );

  fwd_select u_fwd_rs2 (
    .rs(e_rs2), .reg_val(e_rs2_val),
    .m_valid(m_valid), .m_reg_wen(m_reg_wen), .m_rd(m_rd), .m_result(m_result),
    .w_valid(w_valid), .w_reg_wen(w_reg_wen), .w_rd(w_rd), .w_data(w_data),
    .value(fwd_rs2)
  );

  assign mux1         = e_asel ? e_pc  : fwd_rs1;
  assign mux2         = e_bsel ? e_imm : fwd_rs2;
  assign e_store_data = fwd_rs2;
  assign e_reg_wen    = e_wen_q & e_valid;
  assign e_is_load    = e_load_q & e_valid;

endmodule
